// File: rtl/ifetch_unit.sv
// Instruction fetch unit: holds the current PC and instruction, issues one
// instruction-memory read per instruction and selects the next PC from the
// control unit's pcsource when the core signals advance.
//
// Optional build macro IFETCH_ALIGN_CHK_EN: when defined, a misaligned
// jr/jalr target traps the unit in an error state (o_addr_err=1) until
// reset. When undefined, the low two target bits are cleared and
// o_addr_err is tied low.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_pcsource,
  input  logic [31:0] i_rs_val,
  input  logic        i_advance,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic        o_inst_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic        o_addr_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10,
    S_ERR   = 2'b11
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_imem_req;
  logic        r_inst_valid;
  logic        w_load_pc;
  logic        w_load_inst;
  logic [31:0] w_pc4;
  logic [31:0] w_pc_next;

  // Next-PC selection; jr/jalr targets always have their low bits cleared
  // (with the alignment check enabled, a misaligned target never gets here).
  function automatic logic [31:0] f_next_pc(
    input logic [1:0]  sel,
    input logic [31:0] pc4,
    input logic [31:0] inst,
    input logic [31:0] rs
  );
    logic [31:0] v;
    case (sel)
      2'b00:   v = pc4;
      2'b01:   v = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
      2'b10:   v = rs & 32'hFFFF_FFFC;
      2'b11:   v = {pc4[31:28], inst[25:0], 2'b00};
      default: v = pc4;
    endcase
    return v;
  endfunction

  assign w_pc4     = r_pc + 32'd4;
  assign w_pc_next = f_next_pc(i_pcsource, w_pc4, r_inst, i_rs_val);

`ifdef IFETCH_ALIGN_CHK_EN
  logic w_set_err;
  logic r_addr_err;
`endif

  // Next-state and load-enable decode; inputs only matter in the state that owns them.
  always_comb begin
    w_state_next = r_state;
    w_load_pc    = 1'b0;
    w_load_inst  = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
    w_set_err    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          w_state_next = S_HOLD;
          w_load_inst  = 1'b1;
        end else begin
          w_state_next = S_FETCH;
        end
      end
      S_HOLD: begin
        if (i_advance) begin
`ifdef IFETCH_ALIGN_CHK_EN
          if ((i_pcsource == 2'b10) && (i_rs_val[1:0] != 2'b00)) begin
            w_state_next = S_ERR;
            w_set_err    = 1'b1;
          end else begin
            w_state_next = S_FETCH;
            w_load_pc    = 1'b1;
          end
`else
          w_state_next = S_FETCH;
          w_load_pc    = 1'b1;
`endif
        end else begin
          w_state_next = S_HOLD;
        end
      end
      S_ERR: begin
        w_state_next = S_ERR;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Registered status outputs, decoded from the state being entered so they line up with r_state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      r_imem_req   <= (w_state_next == S_FETCH);
      r_inst_valid <= (w_state_next == S_HOLD);
    end
  end

  // Program counter: changes only on an accepted advance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (w_load_pc) begin
      r_pc <= w_pc_next;
    end else begin
      r_pc <= r_pc;
    end
  end

  // Instruction register: captures read data on the acknowledging edge only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inst <= 32'h0000_0000;
    end else if (w_load_inst) begin
      r_inst <= i_imem_rdata;
    end else begin
      r_inst <= r_inst;
    end
  end

`ifdef IFETCH_ALIGN_CHK_EN
  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr_err <= 1'b0;
    end else if (w_set_err) begin
      r_addr_err <= 1'b1;
    end else begin
      r_addr_err <= r_addr_err;
    end
  end

  assign o_addr_err = r_addr_err;
`else
  assign o_addr_err = 1'b0;
`endif

  assign o_imem_req   = r_imem_req;
  assign o_imem_addr  = r_pc;
  assign o_inst       = r_inst;
  assign o_inst_valid = r_inst_valid;
  assign o_pc         = r_pc;
  assign o_pc4        = w_pc4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: expected fetch addresses are queued
// when an advance is driven and compared when the unit raises its request.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] rs_val = 32'h0000_0000;
  logic        advance = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        addr_err;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_inst;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_pcsource(pcsource), .i_rs_val(rs_val),
    .i_advance(advance), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata), .o_inst(inst),
    .o_inst_valid(inst_valid), .o_pc(pc), .o_pc4(pc4), .o_addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Reference next-PC model, written in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [1:0] ps, input logic [31:0] cur,
                                             input logic [31:0] ins, input logic [31:0] rs);
    logic [31:0] p4;
    logic signed [31:0] off;
    p4  = cur + 32'd4;
    off = $signed({{16{ins[15]}}, ins[15:0]}) * 32'sd4;
    case (ps)
      2'b00:   return p4;
      2'b01:   return p4 + off;
      2'b10:   return rs & 32'hFFFF_FFFC;
      default: return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a fetch request.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Serve one fetch after dly wait cycles; reports what was observed.
  task automatic run_fetch(input logic [31:0] w, input int dly, output bit ok,
                           output logic [31:0] addr, output bit stable);
    wait_req(ok);
    addr   = imem_addr;
    stable = ok;
    if (ok) begin
      for (int i = 0; i < dly; i++) begin
        imem_rdata = $urandom;
        advance    = 1'($urandom_range(0, 1));
        pcsource   = 2'($urandom_range(0, 3));
        rs_val     = $urandom;
        tick();
        if (imem_addr !== addr || imem_req !== 1'b1) stable = 1'b0;
      end
      advance    = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = w;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  task automatic do_advance(input logic [1:0] ps, input logic [31:0] rs);
    pcsource = ps;
    rs_val   = rs;
    advance  = 1'b1;
    tick();
    advance  = 1'b0;
    pcsource = 2'($urandom_range(0, 3));
    rs_val   = $urandom;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b1;
    tick();
    tick();
    n_checks += 6;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
    if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h expected 0", inst); end
    if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h expected 0", pc); end
    if (pc4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc4: got %h expected 4", pc4); end
    if (addr_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", addr_err); end
    rst = 1'b0;
    exp_q.push_back(32'h0000_0000);
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b expected 0", imem_req); end
    tick();
    e = exp_q.pop_front();
    n_checks += 2;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", imem_req); end
    if (imem_addr !== e) begin n_fail++; $display("FAIL first_addr: got %h expected %h", imem_addr, e); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] e;
    rst = 1'b1; imem_ack = 1'b1; advance = 1'b1; pcsource = 2'b00; imem_rdata = 32'h0;
    tick();
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if ((k % 2) == 0) begin
        e = exp_q.pop_front();
        if (imem_req !== 1'b1 || imem_addr !== e) begin
          n_fail++; $display("FAIL zw_fetch%0d: got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, e);
        end
      end else begin
        if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
          n_fail++; $display("FAIL zw_hold%0d: got valid=%b req=%b expected valid=1 req=0", k, inst_valid, imem_req);
        end
      end
    end
    imem_ack = 1'b0; advance = 1'b0;
    m_pc = 32'hC; m_inst = 32'h0;
  endtask

  task automatic test_branch();
    bit ok, st; logic [31:0] a, e;
    exp_q.push_back(32'h0000_0010);
    do_advance(2'b00, 32'h0);
    run_fetch(32'h1000_FFFE, 2, ok, a, st);
    e = exp_q.pop_front();
    n_checks += 4;
    if (!ok || a !== e) begin n_fail++; $display("FAIL br_seq_addr: got %h expected %h", a, e); end
    if (!st) begin n_fail++; $display("FAIL br_addr_stable: got unstable expected stable"); end
    if (inst !== 32'h1000_FFFE || inst_valid !== 1'b1) begin n_fail++; $display("FAIL br_inst: got %h/%b expected 1000fffe/1", inst, inst_valid); end
    if (pc !== 32'h10 || pc4 !== 32'h14) begin n_fail++; $display("FAIL br_pc: got %h/%h expected 10/14", pc, pc4); end
    exp_q.push_back(32'h0000_000C);
    do_advance(2'b01, 32'hDEAD_BEEF);
    run_fetch(32'h0, 0, ok, a, st);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || a !== e) begin n_fail++; $display("FAIL br_target: got %h expected %h", a, e); end
    m_pc = 32'hC; m_inst = 32'h0;
  endtask

  task automatic test_jump();
    bit ok, st; logic [31:0] a, e;
    exp_q.push_back(32'h3000_0000);
    do_advance(2'b10, 32'h3000_0000);
    run_fetch(32'h0800_0040, 1, ok, a, st);
    e = exp_q.pop_front();
    n_checks += 2;
    if (!ok || a !== e) begin n_fail++; $display("FAIL jr_aligned: got %h expected %h", a, e); end
    if (pc4 !== 32'h3000_0004) begin n_fail++; $display("FAIL j_pc4: got %h expected 30000004", pc4); end
    exp_q.push_back(32'h3000_0100);
    do_advance(2'b11, 32'h0);
    run_fetch(32'h0, 0, ok, a, st);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || a !== e) begin n_fail++; $display("FAIL j_target: got %h expected %h", a, e); end
  endtask

  task automatic test_pc_wrap();
    bit ok, st; logic [31:0] a, e;
    exp_q.push_back(32'hFFFF_FFFC);
    do_advance(2'b10, 32'hFFFF_FFFC);
    run_fetch(32'h0, 0, ok, a, st);
    e = exp_q.pop_front();
    n_checks += 2;
    if (!ok || a !== e) begin n_fail++; $display("FAIL wrap_addr: got %h expected %h", a, e); end
    if (pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h expected 0", pc4); end
    exp_q.push_back(32'h0);
    do_advance(2'b00, 32'h0);
    run_fetch(32'h0, 0, ok, a, st);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || a !== e) begin n_fail++; $display("FAIL wrap_next: got %h expected %h", a, e); end
    m_pc = 32'h0;
  endtask

  task automatic test_jr_align();
    bit ok, st; logic [31:0] a, e;
`ifdef IFETCH_ALIGN_CHK_EN
    do_advance(2'b10, 32'h0000_0042);
    n_checks += 2;
    if (addr_err !== 1'b1) begin n_fail++; $display("FAIL align_err: got %b expected 1", addr_err); end
    if (pc !== m_pc) begin n_fail++; $display("FAIL align_pc_hold: got %h expected %h", pc, m_pc); end
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; advance = 1'b1;
      tick();
      n_checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || addr_err !== 1'b1) begin
        n_fail++; $display("FAIL align_stuck%0d: got req=%b valid=%b err=%b expected 0/0/1", i, imem_req, inst_valid, addr_err);
      end
    end
    imem_ack = 1'b0; advance = 1'b0;
`else
    exp_q.push_back(32'h0000_0040);
    do_advance(2'b10, 32'h0000_0042);
    run_fetch(32'h0, 0, ok, a, st);
    e = exp_q.pop_front();
    n_checks += 2;
    if (!ok || a !== e) begin n_fail++; $display("FAIL align_mask: got %h expected %h", a, e); end
    if (addr_err !== 1'b0) begin n_fail++; $display("FAIL align_noerr: got %b expected 0", addr_err); end
`endif
  endtask

  task automatic test_delayed_ack_reset();
    bit ok, st; logic [31:0] a, e;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_req(ok);
    tick();
    imem_rdata = 32'h1234_5678;
    tick();
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || pc !== 32'h0 || inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst: got req=%b pc=%h valid=%b expected 0/0/0", imem_req, pc, inst_valid);
    end
    tick();
    rst = 1'b0;
    exp_q.push_back(32'h0);
    run_fetch(32'hCAFE_0001, 3, ok, a, st);
    e = exp_q.pop_front();
    n_checks += 3;
    if (!ok || a !== e) begin n_fail++; $display("FAIL refetch_addr: got %h expected %h", a, e); end
    if (!st) begin n_fail++; $display("FAIL delay_stable: got unstable expected stable"); end
    if (inst !== 32'hCAFE_0001 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL delay_inst: got %h/%b expected cafe0001/1", inst, inst_valid); end
    m_pc = 32'h0; m_inst = 32'hCAFE_0001;
  endtask

  task automatic test_back_to_back();
    bit ok, st; logic [31:0] a, e, w, rs; logic [1:0] ps;
    for (int n = 0; n < 24; n++) begin
      imem_ack = 1'b1; imem_rdata = $urandom;
      tick();
      imem_ack = 1'b0;
      n_checks++;
      if (inst !== m_inst || inst_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_stray_ack%0d: got %h/%b expected %h/1", n, inst, inst_valid, m_inst);
      end
      ps = 2'($urandom_range(0, 3));
      rs = $urandom;
`ifdef IFETCH_ALIGN_CHK_EN
      rs = rs & 32'hFFFF_FFFC;
`endif
      e = model_next(ps, m_pc, m_inst, rs);
      exp_q.push_back(e);
      do_advance(ps, rs);
      w = $urandom;
      run_fetch(w, int'($urandom_range(0, 3)), ok, a, st);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || a !== e || !st || inst !== w || pc !== e || pc4 !== e + 32'd4) begin
        n_fail++; $display("FAIL b2b_%0d: got addr=%h inst=%h pc4=%h expected addr=%h inst=%h pc4=%h", n, a, inst, pc4, e, w, e + 32'd4);
      end
      m_pc = e; m_inst = w;
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_branch();
    test_jump();
    test_pc_wrap();
    test_jr_align();
    test_delayed_ack_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
